sel_pipe: RTL and testbench

Parametrised N-channel, W-bit select stage with a registered valid/ready output and a 2-entry skid buffer. It is the pipelined successor to the fixed 2/3/4-input combinational selectors used for operand and forwarding selection in the CPU datapath. Unlike those selectors, it registers its output, honours downstream back-pressure without dropping data, and supports pipeline flush. It sits between a producer stage and a consumer stage where the selected value must cross a pipeline boundary.

---
 rtl/sel_pipe.sv | 102 ++++++++++
 tb/tb_sel_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sel_pipe.sv
// sel_pipe: registered N-channel select stage with valid/ready handshake and 2-entry skid buffer.
// Define SEL_PIPE_ERR_EN to add the saturating out-of-range select counter err_cnt.
module sel_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
`ifdef SEL_PIPE_ERR_EN
   ,output logic [7:0]         err_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d, sel_val;
    logic [SELW-1:0]  main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
    logic             in_ready_q, in_ready_d, acc, xfer;
    // Unused select codes read as zero so an out-of-range sel yields all-zero data.
    logic [WIDTH-1:0] chan [2**SELW];
    for (genvar k = 0; k < 2**SELW; k++) begin : g_chan
        if (k < N) begin : g_in
            assign chan[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_zero
            assign chan[k] = '0;
        end
    end
    assign sel_val   = chan[sel];
    assign out_valid = state_q != EMPTY;
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign in_ready  = in_ready_q;
    assign acc       = in_valid && in_ready_q;
    assign xfer      = out_valid && out_ready;
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        case (state_q)
            EMPTY: if (acc) begin
                state_d     = ONE;
                main_data_d = sel_val;
                main_sel_d  = sel;
            end
            ONE: if (acc && !xfer) begin
                state_d     = FULL;
                skid_data_d = sel_val;
                skid_sel_d  = sel;
            end else if (acc) begin
                main_data_d = sel_val;
                main_sel_d  = sel;
            end else if (xfer) begin
                state_d = EMPTY;
            end
            FULL: if (xfer) begin
                state_d     = ONE;
                main_data_d = skid_data_q;
                main_sel_d  = skid_sel_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        in_ready_d = state_d != FULL;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
        end
    end
`ifdef SEL_PIPE_ERR_EN
    logic [7:0] err_q, err_d;
    assign err_d   = (acc && 32'(sel) >= N && err_q != 8'hff) ? err_q + 8'd1 : err_q;
    assign err_cnt = err_q;
    always_ff @(posedge clk) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_sel_pipe.sv
// tb_sel_pipe: directed and scoreboarded checks of sel_pipe (N=4 main instance, N=3 out-of-range instance).
module tb_sel_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic         reset, in_valid, flush, out_ready, in_ready, out_valid;
    logic [127:0] in_data;
    logic [1:0]   sel, out_sel;
    logic [31:0]  out_data;
    logic [95:0]  b_data;
    logic [1:0]   b_sel, b_osel;
    logic         b_valid, b_ready, b_flush, b_ovalid, b_oready;
    logic [31:0]  b_odata;
`ifdef SEL_PIPE_ERR_EN
    logic [7:0]   err_a, err_b;
`endif
    int checks = 0, fails = 0;

    sel_pipe #(.WIDTH(32), .N(4), .SELW(2)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef SEL_PIPE_ERR_EN
       ,.err_cnt(err_a)
`endif
    );
    sel_pipe #(.WIDTH(32), .N(3), .SELW(2)) dut3 (
        .clk(clk), .reset(reset), .in_data(b_data), .sel(b_sel), .in_valid(b_valid),
        .in_ready(b_ready), .flush(b_flush), .out_data(b_odata), .out_sel(b_osel),
        .out_valid(b_ovalid), .out_ready(b_oready)
`ifdef SEL_PIPE_ERR_EN
       ,.err_cnt(err_b)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; sel = '0;
        b_valid = 1'b0; b_flush = 1'b0; b_oready = 1'b1; b_sel = '0;
        in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        b_data  = {32'h33, 32'h22, 32'h11};
        step; step;
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_sel !== 2'd0) begin fails++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (b_ready !== 1'b1) begin fails++; $display("FAIL reset_b_in_ready got %b want 1", b_ready); end
`ifdef SEL_PIPE_ERR_EN
        checks++; if (err_b !== 8'd0) begin fails++; $display("FAIL reset_err_cnt got %0d want 0", err_b); end
`endif
    endtask

    task automatic test_select;
        sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sel_out_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h33) begin fails++; $display("FAIL sel_out_data got %h want 33", out_data); end
        checks++; if (out_sel !== 2'd2) begin fails++; $display("FAIL sel_out_sel got %0d want 2", out_sel); end
        step;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sel_drain got %b want 0", out_valid); end
    endtask

    task automatic test_out_of_range;
        b_sel = 2'd3; b_valid = 1'b1;
        step;
        b_valid = 1'b0;
        checks++; if (b_ovalid !== 1'b1) begin fails++; $display("FAIL oor_valid got %b want 1", b_ovalid); end
        checks++; if (b_odata !== 32'h0) begin fails++; $display("FAIL oor_data got %h want 0", b_odata); end
        checks++; if (b_osel !== 2'd3) begin fails++; $display("FAIL oor_sel got %0d want 3", b_osel); end
`ifdef SEL_PIPE_ERR_EN
        checks++; if (err_b !== 8'd1) begin fails++; $display("FAIL oor_err1 got %0d want 1", err_b); end
`endif
        b_sel = 2'd1; b_valid = 1'b1;
        step;
        b_valid = 1'b0;
        checks++; if (b_odata !== 32'h22) begin fails++; $display("FAIL n3_sel1 got %h want 22", b_odata); end
`ifdef SEL_PIPE_ERR_EN
        checks++; if (err_b !== 8'd1) begin fails++; $display("FAIL inrange_no_err got %0d want 1", err_b); end
`endif
        b_sel = 2'd3; b_valid = 1'b1;
        repeat (299) step;
        b_valid = 1'b0;
        step;
        checks++; if (b_ovalid !== 1'b0) begin fails++; $display("FAIL oor_drain got %b want 0", b_ovalid); end
`ifdef SEL_PIPE_ERR_EN
        checks++; if (err_b !== 8'd255) begin fails++; $display("FAIL oor_err_sat got %0d want 255", err_b); end
`endif
    endtask

    task automatic test_back_to_back;
        int sent, got;
        logic [31:0] exp [4];
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        sent = 0; got = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = c >= 4;
            in_valid = sent < 4;
            sel = 2'(sent);
            if (c == 2 || c == 3) begin
                checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_in_ready c=%0d got %b want 0", c, in_ready); end
            end
            if (c == 3) begin
                checks++; if (out_data !== 32'h11) begin fails++; $display("FAIL b2b_stable got %h want 11", out_data); end
            end
            if (c == 5) begin
                checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_release_in_ready got %b want 1", in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (got >= 4 || out_data !== exp[got]) begin fails++; $display("FAIL b2b_order idx=%0d got %h want %h", got, out_data, exp[got]); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            step;
        end
        in_valid = 1'b0;
        checks++; if (got !== 4) begin fails++; $display("FAIL b2b_count got %0d want 4", got); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        step;
        sel = 2'd1;
        step;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_full got %b want 0", in_ready); end
        flush = 1'b1; sel = 2'd3;
        step;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_full_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_full_in_ready got %b want 1", in_ready); end
        in_valid = 1'b1; sel = 2'd0;
        step;
        flush = 1'b1; sel = 2'd3;
        step;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop_valid got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost i=%0d got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_full;
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
        step;
        sel = 2'd3;
        step;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_pre_full got %b want 0", in_ready); end
        reset = 1'b1;
        step;
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_full_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL rst_full_data got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_full_in_ready got %b want 1", in_ready); end
`ifdef SEL_PIPE_ERR_EN
        checks++; if (err_b !== 8'd0) begin fails++; $display("FAIL rst_err_cnt got %0d want 0", err_b); end
`endif
    endtask

    task automatic test_random;
        logic [33:0] q [$];
        int sent, got;
        sent = 0; got = 0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            in_valid = sent < 1000 && $urandom_range(0, 1) == 1;
            sel = 2'($urandom_range(0, 3));
            in_data = {$urandom, $urandom, $urandom, $urandom};
            out_ready = $urandom_range(0, 3) != 0;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0 || {out_sel, out_data} !== q[0]) begin
                    fails++;
                    $display("FAIL rand_beat idx=%0d got %0d:%h want %h", got, out_sel, out_data, q.size() ? q[0] : 34'h0);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back({sel, in_data[32*int'(sel) +: 32]});
                sent++;
            end
            step;
        end
        in_valid = 1'b0;
        checks++; if (got !== 1000) begin fails++; $display("FAIL rand_timeout got %0d want 1000", got); end
    endtask

    initial begin
        test_reset;
        test_select;
        test_out_of_range;
        test_back_to_back;
        test_flush;
        test_reset_full;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
